// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised general-purpose register file with a busy scoreboard.
//
// Two combinational read ports with same-cycle write-to-read bypass, one posedge
// write port, an un-bypassed debug read port, and one busy bit per register that
// tracks outstanding multicycle writes (set on issue, cleared on writeback).
//
// Ports:
//   clk, rst_n                  clock (posedge), asynchronous active-low clear
//   rf_wen/addr_w/data_w        writeback port
//   rf_addr_r1/r2 -> data_r1/r2 read ports (bypassed), busy_r1/r2 pending flags
//   rf_issue_en/issue_addr      mark a register pending
//   rf_dbg_addr -> rf_dbg_data  debug read, registered contents only
//   rf_busy_cnt                 number of pending registers (0..NREG)
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rf_wen,
   input  logic [ADDR_W-1:0] rf_addr_w,
   input  logic [DATA_W-1:0] rf_data_w,
   input  logic [ADDR_W-1:0] rf_addr_r1,
   input  logic [ADDR_W-1:0] rf_addr_r2,
   output logic [DATA_W-1:0] rf_data_r1,
   output logic [DATA_W-1:0] rf_data_r2,
   output logic              rf_busy_r1,
   output logic              rf_busy_r2,
   input  logic              rf_issue_en,
   input  logic [ADDR_W-1:0] rf_issue_addr,
   input  logic [ADDR_W-1:0] rf_dbg_addr,
   output logic [DATA_W-1:0] rf_dbg_data,
   output logic [ADDR_W:0]   rf_busy_cnt
);

   localparam int NREG = 2**ADDR_W;
   localparam bit ZR   = (ZERO_REG != 0);

   logic [DATA_W-1:0] rf_q [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_ok, iss_ok;

   // Writes/issues aimed at a hard-wired zero register are dropped entirely.
   always_comb begin
      wr_ok  = rf_wen && !(ZR && (rf_addr_w == '0));
      iss_ok = rf_issue_en && !(ZR && (rf_issue_addr == '0));
   end

   // Clear before set so a same-address issue wins over the writeback.
   // The count is the popcount of the next busy vector, so it always matches the bits.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[rf_addr_w]     = 1'b0;
      if (iss_ok) busy_d[rf_issue_addr] = 1'b1;
      cnt_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) rf_q[rf_addr_w] <= rf_data_w;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Read side. Outputs are forced to 0 while in reset so a bypassed write
   // cannot leak through during the clear.
   always_comb begin
      rf_data_r1 = '0;
      rf_data_r2 = '0;
      rf_busy_r1 = 1'b0;
      rf_busy_r2 = 1'b0;
      rf_dbg_data = '0;
      if (rst_n) begin
         if (ZR && (rf_addr_r1 == '0))              rf_data_r1 = '0;
         else if (wr_ok && (rf_addr_r1 == rf_addr_w)) rf_data_r1 = rf_data_w;
         else                                        rf_data_r1 = rf_q[rf_addr_r1];

         if (ZR && (rf_addr_r2 == '0))              rf_data_r2 = '0;
         else if (wr_ok && (rf_addr_r2 == rf_addr_w)) rf_data_r2 = rf_data_w;
         else                                        rf_data_r2 = rf_q[rf_addr_r2];

         // A pending writeback hides the busy bit unless a new producer issues
         // to the same register in the same cycle.
         rf_busy_r1 = busy_q[rf_addr_r1] &&
                      !(wr_ok && (rf_addr_r1 == rf_addr_w) &&
                        !(iss_ok && (rf_issue_addr == rf_addr_r1)));
         rf_busy_r2 = busy_q[rf_addr_r2] &&
                      !(wr_ok && (rf_addr_r2 == rf_addr_w) &&
                        !(iss_ok && (rf_issue_addr == rf_addr_r2)));

         rf_dbg_data = rf_q[rf_dbg_addr];
      end
   end

   assign rf_busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed test of regfile_sb, with one instance using a
// hard-wired zero register and one without; both share the same stimulus.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        rf_wen;
   logic [4:0]  rf_addr_w;
   logic [31:0] rf_data_w;
   logic [4:0]  rf_addr_r1, rf_addr_r2;
   logic        rf_issue_en;
   logic [4:0]  rf_issue_addr;
   logic [4:0]  rf_dbg_addr;

   logic [31:0] d1_z, d2_z, dbg_z, d1_n, d2_n, dbg_n;
   logic        b1_z, b2_z, b1_n, b2_n;
   logic [5:0]  cnt_z, cnt_n;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_z (
      .clk(clk), .rst_n(rst_n), .rf_wen(rf_wen), .rf_addr_w(rf_addr_w),
      .rf_data_w(rf_data_w), .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
      .rf_data_r1(d1_z), .rf_data_r2(d2_z), .rf_busy_r1(b1_z), .rf_busy_r2(b2_z),
      .rf_issue_en(rf_issue_en), .rf_issue_addr(rf_issue_addr),
      .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(dbg_z), .rf_busy_cnt(cnt_z)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_n (
      .clk(clk), .rst_n(rst_n), .rf_wen(rf_wen), .rf_addr_w(rf_addr_w),
      .rf_data_w(rf_data_w), .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
      .rf_data_r1(d1_n), .rf_data_r2(d2_n), .rf_busy_r1(b1_n), .rf_busy_r2(b2_n),
      .rf_issue_en(rf_issue_en), .rf_issue_addr(rf_issue_addr),
      .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(dbg_n), .rf_busy_cnt(cnt_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf_wen      = 1'b0;
      rf_issue_en = 1'b0;
   endtask

   function automatic logic [31:0] pat(input int unsigned i);
      return 32'hC0DE_0000 + (i * 32'h0000_0101);
   endfunction

   initial begin
      rst_n = 1'b0;
      rf_wen = 1'b0; rf_addr_w = '0; rf_data_w = '0;
      rf_addr_r1 = '0; rf_addr_r2 = '0;
      rf_issue_en = 1'b0; rf_issue_addr = '0; rf_dbg_addr = '0;

      // Reset state
      tick();
      chk("rst_cnt_z", 32'(cnt_z), 32'd0);
      chk("rst_cnt_n", 32'(cnt_n), 32'd0);
      chk("rst_d1_n", d1_n, 32'd0);
      chk("rst_b1_n", 32'(b1_n), 32'd0);
      rst_n = 1'b1;

      // Asynchronous clear: write r5, issue r6, then pulse reset mid-cycle
      tick();
      rf_wen = 1'b1; rf_addr_w = 5'd5; rf_data_w = 32'hDEADBEEF;
      rf_issue_en = 1'b1; rf_issue_addr = 5'd6;
      rf_addr_r1 = 5'd5; rf_dbg_addr = 5'd5;
      tick();
      idle();
      #1;
      chk("pre_rst_r5", d1_n, 32'hDEADBEEF);
      chk("pre_rst_cnt", 32'(cnt_n), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_r5", d1_n, 32'd0);
      chk("async_dbg", dbg_n, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_r5", d1_n, 32'd0);
      chk("post_rst_cnt", 32'(cnt_n), 32'd0);

      // Write with same-cycle bypass; debug port shows only registered value
      rf_wen = 1'b1; rf_addr_w = 5'd7; rf_data_w = 32'h12345678;
      rf_addr_r1 = 5'd7; rf_dbg_addr = 5'd7;
      #1;
      chk("bypass_r1", d1_n, 32'h12345678);
      chk("dbg_before", dbg_n, 32'd0);
      tick();
      idle();
      #1;
      chk("dbg_after", dbg_n, 32'h12345678);
      chk("r7_after", d1_z, 32'h12345678);

      // Zero register: write and issue r0 on both instances
      rf_wen = 1'b1; rf_addr_w = 5'd0; rf_data_w = 32'hFFFFFFFF;
      rf_issue_en = 1'b1; rf_issue_addr = 5'd0;
      rf_addr_r1 = 5'd0; rf_addr_r2 = 5'd0; rf_dbg_addr = 5'd0;
      #1;
      chk("zr_bypass_z", d1_z, 32'd0);
      chk("zr_bypass_n", d1_n, 32'hFFFFFFFF);
      tick();
      idle();
      #1;
      chk("zr_r1_z", d1_z, 32'd0);
      chk("zr_r2_z", d2_z, 32'd0);
      chk("zr_dbg_z", dbg_z, 32'd0);
      chk("zr_busy_z", 32'(b1_z), 32'd0);
      chk("zr_cnt_z", 32'(cnt_z), 32'd0);
      chk("zr_r1_n", d1_n, 32'hFFFFFFFF);
      chk("zr_dbg_n", dbg_n, 32'hFFFFFFFF);
      chk("zr_busy_n", 32'(b1_n), 32'd1);
      chk("zr_cnt_n", 32'(cnt_n), 32'd1);
      // Retire the ordinary instance's pending r0
      rf_wen = 1'b1; rf_addr_w = 5'd0; rf_data_w = 32'd0;
      tick();
      idle();
      chk("zr_clr_cnt_n", 32'(cnt_n), 32'd0);

      // Scoreboard basic
      rf_issue_en = 1'b1; rf_issue_addr = 5'd3;
      tick();
      chk("sb_cnt1", 32'(cnt_z), 32'd1);
      rf_issue_addr = 5'd4;
      tick();
      chk("sb_cnt2", 32'(cnt_z), 32'd2);
      idle();
      rf_addr_r1 = 5'd3; rf_addr_r2 = 5'd4;
      #1;
      chk("sb_busy3", 32'(b1_z), 32'd1);
      rf_wen = 1'b1; rf_addr_w = 5'd3; rf_data_w = 32'h33;
      #1;
      chk("sb_busy3_wb", 32'(b1_z), 32'd0);
      tick();
      idle();
      #1;
      chk("sb_cnt_after_wb", 32'(cnt_z), 32'd1);
      chk("sb_busy3_after", 32'(b1_z), 32'd0);
      chk("sb_busy4", 32'(b2_z), 32'd1);

      // Simultaneous issue and write
      rf_issue_en = 1'b1; rf_issue_addr = 5'd9;
      tick();
      chk("sim_cnt_pre", 32'(cnt_z), 32'd2);
      rf_wen = 1'b1; rf_addr_w = 5'd9; rf_data_w = 32'hA5A5A5A5;
      rf_addr_r1 = 5'd9;
      #1;
      chk("sim_busy_comb", 32'(b1_z), 32'd1);
      tick();
      idle();
      #1;
      chk("sim_r9", d1_z, 32'hA5A5A5A5);
      chk("sim_busy9", 32'(b1_z), 32'd1);
      chk("sim_cnt", 32'(cnt_z), 32'd2);
      rf_issue_en = 1'b1; rf_issue_addr = 5'd10;
      rf_wen = 1'b1; rf_addr_w = 5'd9; rf_data_w = 32'd0;
      rf_addr_r2 = 5'd10;
      tick();
      idle();
      #1;
      chk("mix_cnt", 32'(cnt_z), 32'd2);
      chk("mix_busy9", 32'(b1_z), 32'd0);
      chk("mix_busy10", 32'(b2_z), 32'd1);

      // Full scoreboard from a clean state
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         rf_issue_en = 1'b1; rf_issue_addr = 5'(i);
         tick();
      end
      idle();
      #1;
      chk("full_cnt_n", 32'(cnt_n), 32'd32);
      chk("full_cnt_z", 32'(cnt_z), 32'd31);
      for (int unsigned i = 0; i < 32; i++) begin
         rf_wen = 1'b1; rf_addr_w = 5'(i); rf_data_w = pat(i);
         tick();
         if (i == 15) chk("half_cnt_n", 32'(cnt_n), 32'd16);
      end
      idle();
      #1;
      chk("drain_cnt_n", 32'(cnt_n), 32'd0);
      chk("drain_cnt_z", 32'(cnt_z), 32'd0);
      for (int unsigned i = 0; i < 32; i++) begin
         rf_addr_r1 = 5'(i);
         rf_addr_r2 = 5'(31 - i);
         rf_dbg_addr = 5'(i);
         #1;
         chk("rb_r1", d1_n, pat(i));
         chk("rb_r2", d2_n, pat(31 - i));
         chk("rb_dbg", dbg_n, pat(i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
